// File: rtl/rsa_ctrl_pkg.sv
// rsa_ctrl_pkg: shared states, default register map and STATUS layout for rsa_run_ctrl
package rsa_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, ARM, WAIT} state_t;
  localparam int CNT_W = 8;
  localparam logic [15:0] DEF_START_ADDR = 16'hFFFC;
  localparam logic [15:0] DEF_KEY_ADDR = 16'hFFF8;
  localparam logic [15:0] DEF_STATUS_ADDR = 16'hFFF4;
  localparam logic [15:0] DEF_RESULT_ADDR = 16'hFFF0;
  localparam logic [15:0] DEF_REPEAT_ADDR = 16'hFFEC;
  localparam logic [15:0] DEF_CYCLES_ADDR = 16'hFFE8;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_RUN_LSB = 8;
endpackage

// File: rtl/rsa_run_ctrl_if.sv
// rsa_run_ctrl_if: simple-bus write/read port of the run controller
interface rsa_run_ctrl_if #(parameter int ADDR_WIDTH = 16, parameter int DATA_WIDTH = 32);
  logic wr;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic rd;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  modport master (output wr, wrAddr, wrData, rd, rdAddr, input rdData);
  modport slave (input wr, wrAddr, wrData, rd, rdAddr, output rdData);
endinterface

// File: rtl/rsa_ctrl_regs.sv
// rsa_ctrl_regs: bus decode, key/repeat registers and combinational read mux
module rsa_ctrl_regs import rsa_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int KEY_SEL_WIDTH = 2,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(DEF_START_ADDR),
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR = ADDR_WIDTH'(DEF_KEY_ADDR),
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(DEF_STATUS_ADDR),
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR = ADDR_WIDTH'(DEF_RESULT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] REPEAT_ADDR = ADDR_WIDTH'(DEF_REPEAT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] CYCLES_ADDR = ADDR_WIDTH'(DEF_CYCLES_ADDR)
) (
  input logic clk,
  input logic rst_n,
  rsa_run_ctrl_if.slave bus,
  input logic busy,
  input logic done,
  input logic timeout,
  input logic [CNT_W-1:0] run_cnt,
  input logic [DATA_WIDTH-1:0] result,
  input logic [DATA_WIDTH-1:0] cycles,
  output logic [KEY_SEL_WIDTH-1:0] key_sel,
  output logic [CNT_W-1:0] rep,
  output logic start_req,
  output logic abort_req
);
  logic [DATA_WIDTH-1:0] status;
  logic start_wr, unused_wr;
  assign unused_wr = ^bus.wrData[DATA_WIDTH-1:CNT_W];
  assign start_wr = bus.wr && bus.wrAddr == START_ADDR;
  // abort takes precedence, so a start with both bits set never launches
  assign abort_req = start_wr && bus.wrData[1];
  assign start_req = start_wr && bus.wrData[0] && !bus.wrData[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_sel <= '0;
      rep <= CNT_W'(1);
    end else if (bus.wr && !busy) begin
      if (bus.wrAddr == KEY_ADDR) key_sel <= bus.wrData[KEY_SEL_WIDTH-1:0];
      if (bus.wrAddr == REPEAT_ADDR) rep <= bus.wrData[CNT_W-1:0];
    end
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    status[ST_TIMEOUT] = timeout;
    status[ST_RUN_LSB +: CNT_W] = run_cnt;
  end
  assign bus.rdData = !bus.rd ? '0 :
                      bus.rdAddr == STATUS_ADDR ? status :
                      bus.rdAddr == RESULT_ADDR ? result :
                      bus.rdAddr == CYCLES_ADDR ? cycles :
                      bus.rdAddr == KEY_ADDR ? DATA_WIDTH'(key_sel) :
                      bus.rdAddr == REPEAT_ADDR ? DATA_WIDTH'(rep) : '0;
endmodule

// File: rtl/rsa_run_ctrl.sv
// rsa_run_ctrl: launches the RSA core repeatedly on a key slot and captures the last result.
// Define RSA_CTRL_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES.
module rsa_run_ctrl import rsa_ctrl_pkg::*; #(
`ifdef RSA_CTRL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 100000,
`endif
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int KEY_SEL_WIDTH = 2,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(DEF_START_ADDR),
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR = ADDR_WIDTH'(DEF_KEY_ADDR),
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(DEF_STATUS_ADDR),
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR = ADDR_WIDTH'(DEF_RESULT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] REPEAT_ADDR = ADDR_WIDTH'(DEF_REPEAT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] CYCLES_ADDR = ADDR_WIDTH'(DEF_CYCLES_ADDR)
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESETN,
  rsa_run_ctrl_if.slave bus,
  output logic [KEY_SEL_WIDTH-1:0] key_sel,
  output logic core_reset,
  input logic core_ready,
  input logic [DATA_WIDTH-1:0] core_result,
  output logic rec_start
);
  state_t state, nxt;
  logic [CNT_W-1:0] rep, run_cnt;
  logic [DATA_WIDTH-1:0] result, cycles;
  logic busy, done, timeout, tmo, start_req, abort_req, last;
  assign busy = state != IDLE;
  assign core_reset = state == LAUNCH;
  assign rec_start = state == LAUNCH;
  // a repeat of 0 still satisfies this after one run
  assign last = ({1'b0, run_cnt} + 1'b1) >= {1'b0, rep};
  rsa_ctrl_regs #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .KEY_SEL_WIDTH(KEY_SEL_WIDTH),
    .START_ADDR(START_ADDR), .KEY_ADDR(KEY_ADDR), .STATUS_ADDR(STATUS_ADDR),
    .RESULT_ADDR(RESULT_ADDR), .REPEAT_ADDR(REPEAT_ADDR), .CYCLES_ADDR(CYCLES_ADDR)
  ) u_regs (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .bus(bus), .busy(busy), .done(done),
    .timeout(timeout), .run_cnt(run_cnt), .result(result), .cycles(cycles),
    .key_sel(key_sel), .rep(rep), .start_req(start_req), .abort_req(abort_req)
  );
  always_comb begin
    nxt = state;
    if (busy && abort_req) nxt = IDLE;
    else
      case (state)
        IDLE: nxt = start_req ? LAUNCH : IDLE;
        LAUNCH: nxt = ARM;
        ARM: nxt = WAIT;
        WAIT: nxt = core_ready ? (last ? IDLE : LAUNCH) : (tmo ? IDLE : WAIT);
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      result <= '0;
      cycles <= '0;
      run_cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start_req) begin
        cycles <= '0;
        run_cnt <= '0;
        done <= 1'b0;
      end else if (state == WAIT && !abort_req) begin
        cycles <= core_ready && !last ? '0 : &cycles ? cycles : cycles + 1'b1;
        if (core_ready) begin
          result <= core_result;
          run_cnt <= run_cnt + 1'b1;
          done <= last;
        end
      end
    end
`ifdef RSA_CTRL_TIMEOUT_EN
  assign tmo = state == WAIT && !core_ready && !abort_req && cycles >= DATA_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) timeout <= 1'b0;
    else if (state == IDLE && start_req) timeout <= 1'b0;
    else if (tmo) timeout <= 1'b1;
`else
  assign tmo = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rsa_run_ctrl.sv
// tb_rsa_run_ctrl: directed and randomized checks of rsa_run_ctrl against a latency/result core model
module tb_rsa_run_ctrl;
  import rsa_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] key_sel;
  logic core_reset, rec_start, core_ready = 1'b0;
  logic [31:0] core_result = '0;
  int checks = 0, errors = 0;
  int lat_q[$];
  logic [31:0] res_q[$];
  int cnt = -1, pulses = 0, recs = 0;
  bit hold = 1'b0;
  logic [31:0] hold_res = '0, cur_res = '0;

  rsa_run_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_if ();

  always #5 clk = ~clk;

`ifdef RSA_CTRL_TIMEOUT_EN
  rsa_run_ctrl #(.TIMEOUT_CYCLES(50)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus_if), .key_sel(key_sel),
    .core_reset(core_reset), .core_ready(core_ready), .core_result(core_result), .rec_start(rec_start));
`else
  rsa_run_ctrl dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus_if), .key_sel(key_sel),
    .core_reset(core_reset), .core_ready(core_ready), .core_result(core_result), .rec_start(rec_start));
`endif

  // Core model: each launch takes the next latency L; ready rises L cycles after the launch cycle and holds
  always @(negedge clk) begin
    if (rec_start) recs++;
    if (core_reset) begin
      pulses++;
      cnt = lat_q.size() > 0 ? lat_q.pop_front() : 100000;
      cur_res = res_q.size() > 0 ? res_q.pop_front() : 32'hDEAD_BEEF;
    end else if (cnt > 0) cnt--;
    core_ready = hold || cnt == 0;
    core_result = hold ? hold_res : cur_res;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
    bus_if.wr = 1'b1; bus_if.wrAddr = a; bus_if.wrData = d;
    @(negedge clk);
    bus_if.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [31:0] d);
    bus_if.rd = 1'b1; bus_if.rdAddr = a;
    #1 d = bus_if.rdData;
    bus_if.rd = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [31:0] e);
    logic [31:0] d;
    rd_reg(a, d);
    check(tag, d, e);
  endtask

  // counts cycles with busy set, starting in the cycle right after the start write
  task automatic run_wait(output int bc);
    logic [31:0] s;
    bc = 0;
    rd_reg(DEF_STATUS_ADDR, s);
    while (s[0] && bc < 5000) begin
      bc++;
      @(negedge clk);
      rd_reg(DEF_STATUS_ADDR, s);
    end
    check("busy_drop", 32'(s[0]), 32'd0);
  endtask

  initial begin
    int bc, p0, r0, n, ne, sum, l;
    logic [31:0] r, r1, r2, d;
    bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.wrAddr = '0; bus_if.wrData = '0; bus_if.rdAddr = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_reset", 32'(core_reset), 32'd0);
    check("rst_rec_start", 32'(rec_start), 32'd0);
    check("rst_key_sel", 32'(key_sel), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_rd("rst_status", DEF_STATUS_ADDR, 32'h0);
    chk_rd("rst_result", DEF_RESULT_ADDR, 32'h0);
    chk_rd("rst_repeat", DEF_REPEAT_ADDR, 32'h1);
    chk_rd("rst_cycles", DEF_CYCLES_ADDR, 32'h0);
    chk_rd("rst_key", DEF_KEY_ADDR, 32'h0);

    @(negedge clk);
    bus_if.wr = 1'b1; bus_if.wrAddr = DEF_KEY_ADDR; bus_if.wrData = 32'h2;
    #1 check("key_before_edge", 32'(key_sel), 32'd0);
    @(negedge clk);
    bus_if.wr = 1'b0;
    check("key_after_edge", 32'(key_sel), 32'd2);
    chk_rd("key_rd", DEF_KEY_ADDR, 32'h2);
    chk_rd("unmapped_rd", 16'h1234, 32'h0);
    chk_rd("start_rd", DEF_START_ADDR, 32'h0);

    // first iteration is the fixed 3-run case, the rest use random repeat, latency and data
    for (int it = 0; it < 8; it++) begin
      n = it == 0 ? 3 : int'($urandom_range(0, 4));
      ne = n == 0 ? 1 : n;
      sum = 0;
      for (int i = 0; i < ne; i++) begin
        l = it == 0 ? 11 : int'($urandom_range(2, 25));
        r = it == 0 ? 32'hA + 32'(i) : $urandom;
        lat_q.push_back(l);
        res_q.push_back(r);
        sum += l + 1;
      end
      @(negedge clk);
      wr_reg(DEF_REPEAT_ADDR, 32'(n));
      chk_rd("repeat_rd", DEF_REPEAT_ADDR, 32'(n));
      p0 = pulses; r0 = recs;
      wr_reg(DEF_START_ADDR, 32'h1);
      run_wait(bc);
      check("run_busy_cycles", 32'(bc), 32'(sum));
      check("run_pulses", 32'(pulses - p0), 32'(ne));
      check("run_rec_pulses", 32'(recs - r0), 32'(ne));
      chk_rd("run_result", DEF_RESULT_ADDR, r);
      chk_rd("run_status", DEF_STATUS_ADDR, (32'(ne) << 8) | 32'h2);
      chk_rd("run_cycles", DEF_CYCLES_ADDR, 32'(l - 1));
    end

    bus_if.rd = 1'b0; bus_if.rdAddr = DEF_STATUS_ADDR;
    #1 check("rd_low_zero", bus_if.rdData, 32'h0);

    // writes while busy are dropped
    @(negedge clk);
    wr_reg(DEF_REPEAT_ADDR, 32'h1);
    r = $urandom;
    lat_q.push_back(12); res_q.push_back(r);
    p0 = pulses;
    wr_reg(DEF_START_ADDR, 32'h1);
    repeat (4) @(negedge clk);
    wr_reg(DEF_KEY_ADDR, 32'h1);
    wr_reg(DEF_REPEAT_ADDR, 32'h5);
    wr_reg(DEF_START_ADDR, 32'h1);
    run_wait(bc);
    check("busy_key_sel", 32'(key_sel), 32'd2);
    chk_rd("busy_repeat", DEF_REPEAT_ADDR, 32'h1);
    chk_rd("busy_result", DEF_RESULT_ADDR, r);
    chk_rd("busy_status", DEF_STATUS_ADDR, 32'h0102);
    repeat (10) @(negedge clk);
    check("busy_pulses", 32'(pulses - p0), 32'd1);

    // abort during the second of three runs
    r1 = $urandom; r2 = $urandom;
    lat_q = {6, 30, 6}; res_q = {r1, r2, 32'h1357};
    wr_reg(DEF_REPEAT_ADDR, 32'h3);
    p0 = pulses;
    wr_reg(DEF_START_ADDR, 32'h1);
    for (int i = 0; i < 200 && pulses - p0 < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    wr_reg(DEF_START_ADDR, 32'h2);
    chk_rd("abort_status", DEF_STATUS_ADDR, 32'h0100);
    chk_rd("abort_result", DEF_RESULT_ADDR, r1);
    repeat (40) @(negedge clk);
    check("abort_pulses", 32'(pulses - p0), 32'd2);
    chk_rd("abort_status_late", DEF_STATUS_ADDR, 32'h0100);
    lat_q.delete(); res_q.delete();

    p0 = pulses;
    wr_reg(DEF_START_ADDR, 32'h3);
    repeat (3) @(negedge clk);
    check("both_bits_pulses", 32'(pulses - p0), 32'd0);
    chk_rd("both_bits_status", DEF_STATUS_ADDR, 32'h0100);

    // ready already high before start must not be taken before the first WAIT cycle
    hold_res = 32'h5A5A_1234; hold = 1'b1;
    wr_reg(DEF_REPEAT_ADDR, 32'h1);
    @(negedge clk);
    p0 = pulses;
    wr_reg(DEF_START_ADDR, 32'h1);
    run_wait(bc);
    check("stale_busy_cycles", 32'(bc), 32'd3);
    check("stale_pulses", 32'(pulses - p0), 32'd1);
    chk_rd("stale_result", DEF_RESULT_ADDR, 32'h5A5A_1234);
    chk_rd("stale_cycles", DEF_CYCLES_ADDR, 32'h1);
    chk_rd("stale_status", DEF_STATUS_ADDR, 32'h0102);
    hold = 1'b0;
    repeat (2) @(negedge clk);

`ifdef RSA_CTRL_TIMEOUT_EN
    p0 = pulses;
    wr_reg(DEF_START_ADDR, 32'h1);
    run_wait(bc);
    check("tmo_busy_cycles", 32'(bc), 32'd52);
    chk_rd("tmo_status", DEF_STATUS_ADDR, 32'h0004);
    lat_q.push_back(5); res_q.push_back(32'h77);
    wr_reg(DEF_START_ADDR, 32'h1);
    run_wait(bc);
    chk_rd("tmo_cleared", DEF_STATUS_ADDR, 32'h0102);
`endif

    // asynchronous reset mid-run
    lat_q.push_back(20); res_q.push_back(32'h99);
    wr_reg(DEF_KEY_ADDR, 32'h3);
    wr_reg(DEF_REPEAT_ADDR, 32'h2);
    wr_reg(DEF_START_ADDR, 32'h1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_core_reset", 32'(core_reset), 32'd0);
    check("mid_rst_key_sel", 32'(key_sel), 32'd0);
    chk_rd("mid_rst_status", DEF_STATUS_ADDR, 32'h0);
    chk_rd("mid_rst_repeat", DEF_REPEAT_ADDR, 32'h1);
    chk_rd("mid_rst_result", DEF_RESULT_ADDR, 32'h0);
    chk_rd("mid_rst_cycles", DEF_CYCLES_ADDR, 32'h0);
    p0 = pulses;
    @(negedge clk);
    rst_n = 1'b1;
    lat_q.delete(); res_q.delete();
    repeat (5) @(negedge clk);
    check("post_rst_pulses", 32'(pulses - p0), 32'd0);
    rd_reg(DEF_STATUS_ADDR, d);
    check("post_rst_idle", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
